dadda_mul_arbiter: RTL and testbench

DADDA_MUL_ARBITER -- requirements
Module: dadda_mul_arbiter

---
 rtl/dadda_mul_arbiter.sv | 110 +++++++++++
 tb/tb_dadda_mul_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dadda_mul_arbiter.sv
// dadda_mul_arbiter: round-robin arbiter sharing one combinational multiplier among NREQ requesters

// dadda: combinational unsigned multiplier reducing partial-product rows through a 3:2 carry-save chain
module dadda #(
    parameter int M = 8,
    parameter int N = 8
) (
    input  logic [M-1:0]   P,
    input  logic [N-1:0]   Q,
    output logic [M+N-1:0] y
);
    localparam int W = M + N;
    genvar j;
    for (j = 0; j < N; j++) begin : row
        logic [W-1:0] pp;
        logic [W-1:0] s;
        logic [W-1:0] c;
        assign pp = Q[j] ? (W'(P) << j) : '0;
        if (j == 0) begin : g_first
            assign s = pp;
            assign c = '0;
        end else begin : g_next
            assign s = row[j-1].s ^ row[j-1].c ^ pp;
            assign c = ((row[j-1].s & row[j-1].c) | (row[j-1].s & pp) | (row[j-1].c & pp)) << 1;
        end
    end
    assign y = row[N-1].s + row[N-1].c;
endmodule

module dadda_mul_arbiter #(
    parameter int M    = 8,
    parameter int N    = 8,
    parameter int NREQ = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*M-1:0]        req_a,
    input  logic [NREQ*N-1:0]        req_b,
    output logic [NREQ-1:0]          req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [M+N-1:0]           rsp_y,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic                     busy
);
    localparam int IW = $clog2(NREQ);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]     state;
    logic [IW-1:0]  rr_ptr;
    logic [IW-1:0]  win;
    logic [IW-1:0]  gnt;
    logic [IW-1:0]  idx;
    logic           found;
    logic [M-1:0]   op_a;
    logic [N-1:0]   op_b;
    logic [M+N-1:0] prod;

    dadda #(.M(M), .N(N)) u_mul (.P(op_a), .Q(op_b), .y(prod));

    // first valid requester at or above rr_ptr, wrapping; descending scan leaves the nearest one in gnt
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = rr_ptr + IW'(k);
            if (req_valid[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
    end

    assign req_ready = (!rst && state == IDLE && found) ? (NREQ'(1) << gnt) : '0;
    assign busy      = state != IDLE;

    // accept in IDLE, capture the product in MUL, hold it in RESP until consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            win       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            rsp_valid <= 1'b0;
            rsp_y     <= '0;
            rsp_id    <= '0;
        end else if (state == IDLE) begin
            if (|(req_valid & req_ready)) begin
                op_a   <= req_a[gnt*M +: M];
                op_b   <= req_b[gnt*N +: N];
                win    <= gnt;
                rr_ptr <= gnt + IW'(1);
                state  <= MUL;
            end
        end else if (state == MUL) begin
            rsp_y     <= prod;
            rsp_id    <= win;
            rsp_valid <= 1'b1;
            state     <= RESP;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
        end
    end
endmodule

// File: tb/tb_dadda_mul_arbiter.sv
// tb_dadda_mul_arbiter: directed vectors plus a randomized scoreboard for the shared-multiplier arbiter
module tb_dadda_mul_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_y;
    logic [1:0]  rsp_id;
    logic        busy;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          id;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] y;
    } vec_t;

    typedef struct {
        logic [1:0]  id;
        logic [15:0] y;
    } exp_t;

    vec_t vecs[6];
    exp_t q[$];

    dadda_mul_arbiter #(.M(8), .N(8), .NREQ(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y), .rsp_id(rsp_id), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic put(input int id, input logic [7:0] a, input logic [7:0] b);
        req_a[id*8 +: 8] = a;
        req_b[id*8 +: 8] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        req_a = '0;
        req_b = '0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rsp_y", 32'(rsp_y), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        rst = 1'b0;
        req_valid = '0;
        @(negedge clk);
    endtask

    initial begin
        int acc;
        int cons;
        int cyc;
        vecs[0] = '{2, 8'd200, 8'd150, 16'd30000};
        vecs[1] = '{0, 8'd0,   8'd173, 16'd0};
        vecs[2] = '{1, 8'd1,   8'd255, 16'd255};
        vecs[3] = '{3, 8'd255, 8'd255, 16'd65025};
        vecs[4] = '{1, 8'd17,  8'd13,  16'd221};
        vecs[5] = '{0, 8'd128, 8'd2,   16'd256};
        do_reset();

        for (int i = 0; i < 6; i++) begin
            req_a = $urandom;
            req_b = $urandom;
            put(vecs[i].id, vecs[i].a, vecs[i].b);
            req_valid = 4'(1 << vecs[i].id);
            rsp_ready = 1'b1;
            #1;
            chk($sformatf("v%0d_grant", i), 32'(req_ready), 32'(1 << vecs[i].id));
            @(negedge clk);
            req_valid = '0;
            req_a = $urandom;
            req_b = $urandom;
            #1;
            chk($sformatf("v%0d_busy", i), 32'(busy), 1);
            chk($sformatf("v%0d_early", i), 32'(rsp_valid), 0);
            @(negedge clk);
            chk($sformatf("v%0d_valid", i), 32'(rsp_valid), 1);
            chk($sformatf("v%0d_y", i), 32'(rsp_y), 32'(vecs[i].y));
            chk($sformatf("v%0d_id", i), 32'(rsp_id), vecs[i].id);
            @(negedge clk);
            chk($sformatf("v%0d_done", i), 32'(rsp_valid), 0);
            chk($sformatf("v%0d_idle", i), 32'(busy), 0);
        end

        do_reset();
        for (int i = 0; i < 4; i++) put(i, 8'(10 + i), 8'(20 + i));
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rr%0d_grant", i), 32'(req_ready), 32'(1 << (i % 4)));
            @(negedge clk);
            chk($sformatf("rr%0d_mul_ready", i), 32'(req_ready), 0);
            @(negedge clk);
            chk($sformatf("rr%0d_resp_ready", i), 32'(req_ready), 0);
            chk($sformatf("rr%0d_id", i), 32'(rsp_id), i % 4);
            chk($sformatf("rr%0d_y", i), 32'(rsp_y), (10 + i % 4) * (20 + i % 4));
            @(negedge clk);
        end

        req_valid = 4'b0001;
        put(0, 8'd255, 8'd255);
        #1;
        chk("bp_grant", 32'(req_ready), 1);
        @(negedge clk);
        req_valid = 4'hF;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp_valid", 32'(rsp_valid), 1);
        chk("bp_y", 32'(rsp_y), 65025);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_valid", i), 32'(rsp_valid), 1);
            chk($sformatf("bp%0d_y", i), 32'(rsp_y), 65025);
            chk($sformatf("bp%0d_id", i), 32'(rsp_id), 0);
            chk($sformatf("bp%0d_ready", i), 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 32'(rsp_valid), 0);
        chk("bp_release_busy", 32'(busy), 0);
        req_valid = '0;
        @(negedge clk);

        req_valid = 4'b0010;
        put(1, 8'd12, 8'd10);
        @(negedge clk);
        chk("mr_busy_mul", 32'(busy), 1);
        rst = 1'b1;
        req_valid = 4'hF;
        #1;
        chk("mr_ready_in_rst", 32'(req_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
        chk("mr_busy", 32'(busy), 0);
        chk("mr_valid", 32'(rsp_valid), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("mr%0d_quiet", i), 32'(rsp_valid), 0);
        end
        req_valid = 4'b1010;
        #1;
        chk("mr_ptr_zero", 32'(req_ready), 32'b0010);
        req_valid = '0;

        acc = 0;
        cons = 0;
        cyc = 0;
        while ((acc < 1000 || q.size() != 0) && cyc < 30000) begin
            @(negedge clk);
            cyc++;
            req_valid = (acc < 1000) ? 4'($urandom) : 4'h0;
            req_a = $urandom;
            req_b = $urandom;
            rsp_ready = (acc < 1000) ? 1'($urandom) : 1'b1;
            #1;
            for (int k = 0; k < 4; k++) begin
                if (req_valid[k] && req_ready[k]) begin
                    q.push_back('{2'(k), 16'(req_a[k*8 +: 8]) * 16'(req_b[k*8 +: 8])});
                    acc++;
                end
            end
            if (rsp_valid && rsp_ready) begin
                cons++;
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rnd_dup: response %0d with nothing outstanding", rsp_y);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rnd_y", 32'(rsp_y), 32'(e.y));
                    chk("rnd_id", 32'(rsp_id), 32'(e.id));
                end
            end
        end
        chk("rnd_budget", 32'(cyc < 30000), 1);
        chk("rnd_accepted", acc, 1000);
        chk("rnd_consumed", cons, 1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
